// File: rtl/pc_pkg.sv
// Shared constants and types for the 8-bit program counter.
package pc_pkg;

  localparam int PC_WIDTH = 8;

  typedef logic [PC_WIDTH-1:0] pc_addr_t;

  localparam pc_addr_t PC_RESET_VECTOR = 8'h00;

  localparam int PC_STEP = 1;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: hold > jump > increment.
// The reset path lives in the register, not here.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int STEP  = PC_STEP
) (
  input  logic             hold,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_next
);

  // Increment is modulo 2^WIDTH, so the step is truncated once here
  // and the adder result is kept to WIDTH bits.
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  // Priority mux: a held PC ignores any jump request in the same cycle.
  always_comb begin
    pc_next = pc + STEP_W;
    if (hold) begin
      pc_next = pc;
    end else if (jump) begin
      pc_next = jump_addr;
    end
  end

endmodule

// File: rtl/pc_8bit.sv
// Program counter for the 8-bit teaching CPU. Advances by STEP each
// clock, loads jump_addr on jump, and wraps modulo 2^WIDTH.
// Optional feature: define PC_8BIT_HOLD_EN to add the hold input,
// which freezes pc (and overrides jump) while high.
module pc_8bit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR,
  parameter int               STEP         = PC_STEP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_addr,
`ifdef PC_8BIT_HOLD_EN
  input  logic             hold,
`endif
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] pc_next;
  logic             hold_sel;

`ifdef PC_8BIT_HOLD_EN
  assign hold_sel = hold;
`else
  // Without the hold feature the mux simply never holds.
  assign hold_sel = 1'b0;
`endif

  pc_next_sel #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_next_sel (
    .hold      (hold_sel),
    .jump      (jump),
    .jump_addr (jump_addr),
    .pc        (pc_reg),
    .pc_next   (pc_next)
  );

  // PC register: async reset forces the vector immediately, otherwise
  // take the selected next value on every rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg <= RESET_VECTOR;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule

// File: tb/tb_pc_8bit.sv
// Directed self-checking bench for pc_8bit with hand-computed values.
// The hold scenario runs only when PC_8BIT_HOLD_EN is defined.
module tb_pc_8bit;

  logic       clk;
  logic       reset;
  logic       jump;
  logic [7:0] jump_addr;
  logic       hold;
  logic [7:0] pc;

  int total;
  int bad;

  pc_8bit dut (
    .clk       (clk),
    .reset     (reset),
    .jump      (jump),
    .jump_addr (jump_addr),
`ifdef PC_8BIT_HOLD_EN
    .hold      (hold),
`endif
    .pc        (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: pc=%02h expected=%02h", tag, got, exp);
    end else begin
      $display("ok   %s: pc=%02h", tag, got);
    end
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    jump      = 1'b0;
    jump_addr = 8'h00;
    hold      = 1'b0;

    // Async reset visible before any clock edge.
    #1;
    chk("reset_t0", pc, 8'h00);

    // Reset dominates jump across edges.
    jump      = 1'b1;
    jump_addr = 8'h55;
    tick();
    chk("reset_vs_jump_0", pc, 8'h00);
    tick();
    chk("reset_vs_jump_1", pc, 8'h00);
    jump = 1'b0;

    // Release reset, count 0x01..0x0A.
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("inc_%0d", i), pc, 8'(i));
    end

    // Single-edge jump then increments.
    jump      = 1'b1;
    jump_addr = 8'hA5;
    tick();
    chk("jump_a5", pc, 8'hA5);
    jump = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("post_jump_%0d", i), pc, 8'(8'hA5 + i));
    end

    // Mid-run reset between edges: immediate drop.
    #3;
    reset = 1'b1;
    #1;
    chk("reset_mid_async", pc, 8'h00);
    tick();
    chk("reset_mid_edge", pc, 8'h00);
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("after_reset_%0d", i), pc, 8'(i));
    end

    // Jump held for several edges; later edges jump to the current pc.
    jump      = 1'b1;
    jump_addr = 8'h40;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("jump_held_%0d", i), pc, 8'h40);
    end
    jump = 1'b0;

    // Wrap-around.
    jump      = 1'b1;
    jump_addr = 8'hFE;
    tick();
    chk("wrap_fe", pc, 8'hFE);
    jump = 1'b0;
    tick();
    chk("wrap_ff", pc, 8'hFF);
    tick();
    chk("wrap_00", pc, 8'h00);

    // First edge after reset release with jump asserted loads jump_addr.
    reset = 1'b1;
    #1;
    chk("reset_again", pc, 8'h00);
    tick();
    reset     = 1'b0;
    jump      = 1'b1;
    jump_addr = 8'h77;
    tick();
    chk("release_jump", pc, 8'h77);
    jump = 1'b0;
    tick();
    chk("release_jump_inc", pc, 8'h78);

`ifdef PC_8BIT_HOLD_EN
    // Hold overrides a simultaneous jump.
    jump      = 1'b1;
    jump_addr = 8'h10;
    tick();
    chk("hold_setup", pc, 8'h10);
    hold      = 1'b1;
    jump_addr = 8'h33;
    tick();
    chk("hold_vs_jump", pc, 8'h10);
    tick();
    chk("hold_twice", pc, 8'h10);
    hold = 1'b0;
    jump = 1'b0;
    tick();
    chk("hold_release", pc, 8'h11);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: pc=%02h expected=finish", pc);
    $fatal(1, "timeout");
  end

endmodule
